// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register: STAGES slices carrying an opaque DATA_W payload, with bubble collapsing, flush and occupancy.
// Latency: STAGES-1 edges from accept to out_valid when unstalled (STAGES=1: visible the cycle after accept).
// Backpressure: in_ready drops only when every slice is full and the output is blocked, or when en=0, flush=1 or RST=1.
// Optional build macro PIPE_STAGE_REG_PERF_EN adds saturating stall_cnt/bubble_cnt outputs.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int STAGES = 1,
  // Derived width; leave at its default.
  parameter int OCC_W  = $clog2(STAGES + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [OCC_W-1:0]  occupancy
`ifdef PIPE_STAGE_REG_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  // Reject unsupported configurations at elaboration time.
  generate
    if (STAGES < 1 || STAGES > 4 || DATA_W < 1) begin : g_bad_cfg
      $error("pipe_stage_reg: STAGES must be 1..4 and DATA_W must be >= 1");
    end
  endgenerate

  // Per-slice state; slice 0 faces the input, slice STAGES-1 drives the output.
  logic [STAGES-1:0] v;
  logic [DATA_W-1:0] d [STAGES];

  // mv[k]: slice k hands its payload onward at the next edge.
  logic [STAGES-1:0] mv;
  logic              xfer_out;
  logic              xfer_in;

  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];
  assign xfer_out  = en & v[STAGES-1] & out_ready;

  // Move chain, evaluated output-first so a departing slice frees its predecessor in the same cycle.
  always_comb begin
    mv           = '0;
    mv[STAGES-1] = xfer_out;
    for (int k = STAGES - 2; k >= 0; k--) begin
      mv[k] = en & v[k] & (~v[k+1] | mv[k+1]);
    end
  end

  // Slice 0 accepts when empty or draining; never depends on in_valid, and is held off by flush and reset.
  assign in_ready = en & ~flush & ~RST & (~v[0] | mv[0]);
  assign xfer_in  = in_valid & in_ready;

  // Slice registers: reset/flush clear everything, otherwise payloads step forward on their move flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        d[k] <= '0;
      end
    end else if (flush) begin
      v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        d[k] <= '0;
      end
    end else if (en) begin
      if (xfer_in) begin
        v[0] <= 1'b1;
        d[0] <= in_data;
      end else if (mv[0]) begin
        v[0] <= 1'b0;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (mv[k-1]) begin
          v[k] <= 1'b1;
          d[k] <= d[k-1];
        end else if (mv[k]) begin
          // Data is left in place so out_data keeps the last departed value.
          v[k] <= 1'b0;
        end
      end
    end
  end

  // Occupancy is a population count of the slice valid bits.
  always_comb begin
    occupancy = '0;
    for (int k = 0; k < STAGES; k++) begin
      occupancy = occupancy + OCC_W'(v[k]);
    end
  end

`ifdef PIPE_STAGE_REG_PERF_EN
  logic stall_evt;
  logic bubble_evt;

  assign stall_evt  = in_valid & ~in_ready & ~flush;
  assign bubble_evt = en & out_ready & ~out_valid;

  // Saturating event counters; only reset clears them, flush leaves them alone.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall_evt && !(&stall_cnt)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (bubble_evt && !(&bubble_cnt)) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg (STAGES=3, DATA_W=32): directed scenarios followed by randomized traffic.
// The reference keeps accepted payloads in an ordered queue together with the number of enabled edges each has seen.
// The output-side checker pops and compares whenever the design presents a payload to a ready consumer.
module tb_pipe_stage_reg;
  localparam int S  = 3;
  localparam int W  = 32;
  localparam int OW = $clog2(S + 1);

  logic          CLK = 1'b0;
  logic          RST;
  logic          en;
  logic          flush;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic [OW-1:0] occupancy;
`ifdef PIPE_STAGE_REG_PERF_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   bubble_cnt;
  longint        stall_m;
  longint        bubble_m;
`endif

  pipe_stage_reg #(.DATA_W(W), .STAGES(S)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_REG_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference state: payloads in flight (oldest first) and enabled edges seen by each.
  logic [W-1:0] mq[$];
  int           mage[$];
  bit           zero_dat = 1'b1;
  bit           p_in_rdy;
  bit           p_out_vld;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Checker and reference update, mid-cycle while inputs and outputs are stable.
  always @(negedge CLK) begin
    if (RST) begin
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_data", 64'(out_data), 64'(0));
      chk("rst_occupancy", 64'(occupancy), 64'(0));
      mq.delete();
      mage.delete();
      zero_dat = 1'b1;
`ifdef PIPE_STAGE_REG_PERF_EN
      chk("rst_stall_cnt", 64'(stall_cnt), 64'(0));
      chk("rst_bubble_cnt", 64'(bubble_cnt), 64'(0));
      stall_m  = 0;
      bubble_m = 0;
`endif
    end else begin
      // A slot frees up unless all STAGES are held and the consumer is blocked.
      p_in_rdy  = en && !flush && ((mq.size() < S) || out_ready);
      // The oldest payload reaches the output once it has seen STAGES-1 enabled edges.
      p_out_vld = (mq.size() > 0) && (mage[0] >= S - 1);

      chk("occupancy", 64'(occupancy), 64'(mq.size()));
      chk("in_ready", 64'(in_ready), 64'(p_in_rdy));
      chk("out_valid", 64'(out_valid), 64'(p_out_vld));
      if (p_out_vld) begin
        chk("out_data", 64'(out_data), 64'(mq[0]));
        zero_dat = 1'b0;
      end else if (zero_dat) begin
        chk("out_data_cleared", 64'(out_data), 64'(0));
      end

`ifdef PIPE_STAGE_REG_PERF_EN
      chk("stall_cnt", 64'(stall_cnt), 64'(stall_m));
      chk("bubble_cnt", 64'(bubble_cnt), 64'(bubble_m));
      if (in_valid && !p_in_rdy && !flush) stall_m++;
      if (en && out_ready && !p_out_vld) bubble_m++;
`endif

      // Apply what the coming edge will do.
      if (flush) begin
        mq.delete();
        mage.delete();
        zero_dat = 1'b1;
      end else if (en) begin
        if (p_out_vld && out_ready) begin
          void'(mq.pop_front());
          void'(mage.pop_front());
        end
        foreach (mage[i]) mage[i] = mage[i] + 1;
        if (in_valid && p_in_rdy) begin
          mq.push_back(in_data);
          mage.push_back(0);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST       = 1'b1;
    en        = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef PIPE_STAGE_REG_PERF_EN
    stall_m  = 0;
    bubble_m = 0;
`endif
    repeat (3) step();
    RST       = 1'b0;
    en        = 1'b1;
    out_ready = 1'b1;

    // Back-to-back stream with a free-running consumer.
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h11 * i;
      step();
    end
    in_valid = 1'b0;
    repeat (5) step();

    // Fill against a blocked consumer, then release it while still offering.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 32'hA0 + i;
      step();
    end
    out_ready = 1'b1;
    repeat (4) step();
    in_valid = 1'b0;
    repeat (4) step();

    // Lone payloads with gaps collapse toward the output.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h5;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    in_valid = 1'b1;
    in_data  = 32'h6;
    step();
    in_valid = 1'b0;
    step();
    out_ready = 1'b1;
    repeat (4) step();

    // Flush a full pipe while a payload is offered; it must never emerge.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'h40 + i;
      step();
    end
    in_data = 32'h77;
    flush   = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();

    // Freeze with en=0 while both sides are willing, then resume.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h61;
    step();
    in_data = 32'h62;
    step();
    en        = 1'b0;
    out_ready = 1'b1;
    in_data   = 32'h63;
    repeat (4) step();
    en = 1'b1;
    repeat (3) step();
    in_valid = 1'b0;
    repeat (6) step();

    // Randomized traffic with an asynchronous reset pulse part-way through.
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      en        = ($urandom_range(0, 7) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      if (i == 1000) begin
        #2;
        RST = 1'b1;
        step();
        RST = 1'b0;
      end else begin
        step();
      end
    end

    // Drain.
    in_valid  = 1'b0;
    flush     = 1'b0;
    en        = 1'b1;
    out_ready = 1'b1;
    repeat (10) step();
    @(negedge CLK);
    #1;
    chk("drained_out_valid", 64'(out_valid), 64'(0));
    chk("drained_occupancy", 64'(occupancy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
